local_bus_reg_slave: RTL

- Register-bank slave consuming local bus master-mode transactions (addr_en/addr/rw_direction/wdata in, rdata/rvalid out); sits directly downstream of the local bus interface.
- Decodes single-cycle requests and performs register writes, plus pipelined reads with a fixed, parameterised latency.
- Provides control, scratch, cycle-counter and error-status registers; used as the DUT-side target for the register-model environment.

---
 rtl/local_bus_reg_pkg.sv | 27 ++
 rtl/local_bus_rd_pipe.sv | 45 ++++
 rtl/local_bus_reg_slave.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/local_bus_reg_pkg.sv
// Shared constants and decode enum for the local bus register slave.
// Address 0x0C (ERR_MASK) exists only when LOCAL_BUS_REG_ERR_INTR_EN is defined.
package local_bus_reg_pkg;

   localparam int unsigned CTRL_ADDR     = 'h00;
   localparam int unsigned COUNTER_ADDR  = 'h04;
   localparam int unsigned ERR_STAT_ADDR = 'h08;
   localparam int unsigned ERR_MASK_ADDR = 'h0C;
   localparam int unsigned SCRATCH_BASE  = 'h10;

   localparam int unsigned CTRL_CNT_EN  = 0;
   localparam int unsigned CTRL_CNT_CLR = 1;

   localparam int unsigned ERR_UNMAPPED = 0;
   localparam int unsigned ERR_RO_WRITE = 1;
   localparam int unsigned ERR_W        = 2;

   typedef enum logic [2:0] {
      DEC_CTRL,
      DEC_COUNTER,
      DEC_ERR,
      DEC_MASK,
      DEC_SCRATCH,
      DEC_UNMAPPED
   } dec_e;

endpackage

// File: rtl/local_bus_rd_pipe.sv
// Fixed-latency read return pipe: valid/data shift register, flushed by reset.
// Data of empty stages is forced to 0 so the output reads 0 when idle.
module local_bus_rd_pipe #(
   parameter int LATENCY    = 2,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_vld,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_vld,
   output logic [DATA_WIDTH-1:0] out_data
);

   logic [LATENCY-1:0]                 vld_pipe;
   logic [LATENCY-1:0][DATA_WIDTH-1:0] dat_pipe;

   for (genvar s = 0; s < LATENCY; s++) begin : g_stage
      if (s == 0) begin : g_head
         always_ff @(posedge clk) begin
            if (reset) begin
               vld_pipe[s] <= 1'b0;
               dat_pipe[s] <= '0;
            end else begin
               vld_pipe[s] <= in_vld;
               dat_pipe[s] <= in_vld ? in_data : '0;
            end
         end
      end else begin : g_body
         always_ff @(posedge clk) begin
            if (reset) begin
               vld_pipe[s] <= 1'b0;
               dat_pipe[s] <= '0;
            end else begin
               vld_pipe[s] <= vld_pipe[s-1];
               dat_pipe[s] <= dat_pipe[s-1];
            end
         end
      end
   end

   assign out_vld  = vld_pipe[LATENCY-1];
   assign out_data = dat_pipe[LATENCY-1];

endmodule

// File: rtl/local_bus_reg_slave.sv
// Register-bank slave on the local bus: CTRL, COUNTER, ERR_STAT, SCRATCH[] with pipelined reads.
// Define LOCAL_BUS_REG_ERR_INTR_EN to add ERR_MASK at 0x0C and a registered irq output.
module local_bus_reg_slave
   import local_bus_reg_pkg::*;
#(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 32,
   parameter int RD_LATENCY  = 2,
   parameter int NUM_SCRATCH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  addr_en,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  rw_direction,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rvalid,
   output logic [DATA_WIDTH-1:0] ctrl_o
`ifdef LOCAL_BUS_REG_ERR_INTR_EN
   ,
   output logic                  irq
`endif
);

   localparam int SIDX_W = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;

   logic [DATA_WIDTH-1:0]                  ctrl;
   logic [DATA_WIDTH-1:0]                  counter;
   logic [ERR_W-1:0]                       err_stat;
   logic [NUM_SCRATCH-1:0][DATA_WIDTH-1:0] scratch;

   dec_e                  dec;
   logic [SIDX_W-1:0]     scr_idx;
   logic [ADDR_WIDTH-1:0] scr_off;
   logic                  wr, rd;
   logic                  cnt_clr;
   logic [ERR_W-1:0]      err_set, err_clr;
   logic [DATA_WIDTH-1:0] rd_val;

`ifdef LOCAL_BUS_REG_ERR_INTR_EN
   logic [ERR_W-1:0] err_mask;
`endif

   assign wr = addr_en & ~rw_direction;
   assign rd = addr_en &  rw_direction;

   assign scr_off = addr - ADDR_WIDTH'(SCRATCH_BASE);

   always_comb begin
      dec     = DEC_UNMAPPED;
      scr_idx = scr_off[SIDX_W+1:2];
      if (addr[1:0] == 2'b00) begin
         if (addr == ADDR_WIDTH'(CTRL_ADDR))
            dec = DEC_CTRL;
         else if (addr == ADDR_WIDTH'(COUNTER_ADDR))
            dec = DEC_COUNTER;
         else if (addr == ADDR_WIDTH'(ERR_STAT_ADDR))
            dec = DEC_ERR;
`ifdef LOCAL_BUS_REG_ERR_INTR_EN
         else if (addr == ADDR_WIDTH'(ERR_MASK_ADDR))
            dec = DEC_MASK;
`endif
         else if (addr >= ADDR_WIDTH'(SCRATCH_BASE) &&
                  scr_off < ADDR_WIDTH'(4 * NUM_SCRATCH))
            dec = DEC_SCRATCH;
      end
   end

   // Every request to an unmapped address flags, reads included.
   always_comb begin
      err_set               = '0;
      err_set[ERR_UNMAPPED] = addr_en && (dec == DEC_UNMAPPED);
      err_set[ERR_RO_WRITE] = wr && (dec == DEC_COUNTER);
      err_clr               = (wr && dec == DEC_ERR) ? wdata[ERR_W-1:0] : '0;
   end

   assign cnt_clr = wr && (dec == DEC_CTRL) && wdata[CTRL_CNT_CLR];

   always_comb begin
      rd_val = '0;
      case (dec)
         DEC_CTRL:    rd_val = ctrl;
         DEC_COUNTER: rd_val = counter;
         DEC_ERR:     rd_val = DATA_WIDTH'(err_stat);
`ifdef LOCAL_BUS_REG_ERR_INTR_EN
         DEC_MASK:    rd_val = DATA_WIDTH'(err_mask);
`endif
         DEC_SCRATCH: rd_val = scratch[scr_idx];
         default:     rd_val = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl     <= '0;
         counter  <= '0;
         err_stat <= '0;
      end else begin
         // cnt_clr is never stored, so CTRL bit1 always reads back 0.
         if (wr && dec == DEC_CTRL)
            ctrl <= wdata & ~(DATA_WIDTH'(1) << CTRL_CNT_CLR);
         if (cnt_clr)
            counter <= '0;
         else if (ctrl[CTRL_CNT_EN])
            counter <= counter + 1'b1;
         // A set in the same cycle as its clear wins.
         err_stat <= (err_stat & ~err_clr) | err_set;
      end
   end

   for (genvar i = 0; i < NUM_SCRATCH; i++) begin : g_scratch
      always_ff @(posedge clk) begin
         if (reset)
            scratch[i] <= '0;
         else if (wr && dec == DEC_SCRATCH && scr_idx == SIDX_W'(i))
            scratch[i] <= wdata;
      end
   end

`ifdef LOCAL_BUS_REG_ERR_INTR_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         err_mask <= '0;
         irq      <= 1'b0;
      end else begin
         if (wr && dec == DEC_MASK)
            err_mask <= wdata[ERR_W-1:0];
         irq <= |(err_stat & err_mask);
      end
   end
`endif

   assign ctrl_o = ctrl;

   local_bus_rd_pipe #(
      .LATENCY    (RD_LATENCY),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rd_pipe (
      .clk      (clk),
      .reset    (reset),
      .in_vld   (rd),
      .in_data  (rd_val),
      .out_vld  (rvalid),
      .out_data (rdata)
   );

endmodule
